sock_box_packer: RTL and testbench

- Downstream stage of the per-type sock counters (acrylic/cotton, high/low).
- Each counter emits a one-cycle completion pulse together with a 3-bit pairs-per-package value.
- This block consumes those package completions and packs them into boxes of BOX_CAP packages.
- It hands full boxes to the conveyor controller via a ready/ack handshake, buffers one package while a full box waits, and reports box totals and fault status for the panel LEDs.

---
 rtl/sock_pkg.sv | 15 +
 rtl/pkg_hold_reg.sv | 27 ++
 rtl/sock_box_packer.sv | 115 +++++++++++
 tb/tb_sock_box_packer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/sock_pkg.sv
// Shared types and constants for the sock box packer and its hold register.
package sock_pkg;

  localparam int unsigned PAC_W       = 3;
  localparam int unsigned PAIRS_W     = 6;
  localparam int unsigned BOX_CAP_DEF = 4;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'b00,
    ST_FILLING = 2'b01,
    ST_FULL    = 2'b10,
    ST_EJECT   = 2'b11
  } state_t;

endpackage

// File: rtl/pkg_hold_reg.sv
// Single-entry package buffer used while a full box waits for the conveyor.
module pkg_hold_reg
  import sock_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             clear,
  input  logic [PAC_W-1:0] pac,
  output logic             hold_full,
  output logic [PAC_W-1:0] hold_pac
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_full <= 1'b0;
      hold_pac  <= '0;
    end else if (clear) begin
      hold_full <= 1'b0;
      hold_pac  <= '0;
    end else if (load) begin
      hold_full <= 1'b1;
      hold_pac  <= pac;
    end
  end

endmodule

// File: rtl/sock_box_packer.sv
// Packs package-complete pulses into boxes of BOX_CAP and hands full boxes
// to the conveyor with a ready/ack handshake.
module sock_box_packer
  import sock_pkg::*;
#(
  parameter int unsigned BOX_CAP   = BOX_CAP_DEF,
  parameter int unsigned BOX_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 co,
  input  logic [PAC_W-1:0]     pac,
  input  logic                 box_ack,
  output logic                 box_ready,
  output logic [PAC_W-1:0]     pkg_cnt,
  output logic [PAIRS_W-1:0]   pairs_in_box,
  output logic [BOX_CNT_W-1:0] box_cnt,
  output logic                 hold_full,
  output logic                 overflow,
  output logic [1:0]           state_led
);

  localparam logic [PAC_W-1:0] CAP = PAC_W'(BOX_CAP);

  state_t               state, state_next;
  logic                 arrival;
  logic [PAC_W-1:0]     pkg_cnt_next;
  logic [PAIRS_W-1:0]   pairs_next;
  logic [BOX_CNT_W-1:0] box_cnt_next;
  logic                 overflow_next;
  logic                 hold_load, hold_clear;
  logic [PAC_W-1:0]     hold_pac;
  logic [PAIRS_W-1:0]   pac_ext, hold_ext;

  assign arrival = co && (pac != '0);
  assign pac_ext  = {{(PAIRS_W-PAC_W){1'b0}}, pac};
  assign hold_ext = {{(PAIRS_W-PAC_W){1'b0}}, hold_pac};

  pkg_hold_reg u_hold (
    .clk       (clk),
    .reset     (reset),
    .load      (hold_load),
    .clear     (hold_clear),
    .pac       (pac),
    .hold_full (hold_full),
    .hold_pac  (hold_pac)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_EMPTY;
    else       state <= state_next;
  end

  always_comb begin
    state_next    = state;
    pkg_cnt_next  = pkg_cnt;
    pairs_next    = pairs_in_box;
    box_cnt_next  = box_cnt;
    overflow_next = overflow;
    hold_load     = 1'b0;
    hold_clear    = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (arrival) begin
          pkg_cnt_next = PAC_W'(1);
          pairs_next   = pac_ext;
          state_next   = ST_FILLING;
        end
      end
      ST_FILLING: begin
        if (arrival) begin
          pkg_cnt_next = pkg_cnt + PAC_W'(1);
          pairs_next   = pairs_in_box + pac_ext;
          if (pkg_cnt_next == CAP) state_next = ST_FULL;
        end
      end
      ST_FULL: begin
        if (arrival) begin
          if (hold_full) overflow_next = 1'b1;
          else           hold_load     = 1'b1;
        end
        // Box count advances as the conveyor takes the box, so it is visible during EJECT.
        if (box_ack) begin
          state_next   = ST_EJECT;
          box_cnt_next = box_cnt + BOX_CNT_W'(1);
        end
      end
      ST_EJECT: begin
        hold_clear   = 1'b1;
        pkg_cnt_next = PAC_W'(hold_full) + PAC_W'(arrival);
        pairs_next   = (hold_full ? hold_ext : '0) + (arrival ? pac_ext : '0);
        state_next   = (pkg_cnt_next == '0) ? ST_EMPTY : ST_FILLING;
      end
      default: state_next = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pkg_cnt      <= '0;
      pairs_in_box <= '0;
      box_cnt      <= '0;
      overflow     <= 1'b0;
    end else begin
      pkg_cnt      <= pkg_cnt_next;
      pairs_in_box <= pairs_next;
      box_cnt      <= box_cnt_next;
      overflow     <= overflow_next;
    end
  end

  assign box_ready = (state == ST_FULL);
  assign state_led = state;

endmodule

// File: tb/tb_sock_box_packer.sv
// Randomized and directed bench for sock_box_packer against a queue-based box model.
module tb_sock_box_packer;

  localparam int CAP = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       co;
  logic [2:0] pac;
  logic       box_ack;
  logic       box_ready;
  logic [2:0] pkg_cnt;
  logic [5:0] pairs_in_box;
  logic [7:0] box_cnt;
  logic       hold_full;
  logic       overflow;
  logic [1:0] state_led;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: contents of the current box, the held package, shipped count.
  int box_q[$];
  int held_q[$];
  bit m_eject;
  int m_ships;
  bit m_ovf;

  sock_box_packer #(.BOX_CAP(CAP), .BOX_CNT_W(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .co           (co),
    .pac          (pac),
    .box_ack      (box_ack),
    .box_ready    (box_ready),
    .pkg_cnt      (pkg_cnt),
    .pairs_in_box (pairs_in_box),
    .box_cnt      (box_cnt),
    .hold_full    (hold_full),
    .overflow     (overflow),
    .state_led    (state_led)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int box_sum();
    int s = 0;
    foreach (box_q[i]) s += box_q[i];
    return s;
  endfunction

  function automatic int exp_led();
    if (m_eject) return 3;
    if (box_q.size() == CAP) return 2;
    if (box_q.size() > 0) return 1;
    return 0;
  endfunction

  task automatic model_reset();
    box_q.delete();
    held_q.delete();
    m_eject = 0;
    m_ships = 0;
    m_ovf   = 0;
  endtask

  task automatic model_step(input bit c, input int p, input bit a);
    bit arr = c && (p != 0);
    if (m_eject) begin
      box_q = held_q;
      held_q.delete();
      if (arr) box_q.push_back(p);
      m_eject = 0;
    end else if (box_q.size() == CAP) begin
      if (arr) begin
        if (held_q.size() == 0) held_q.push_back(p);
        else m_ovf = 1;
      end
      if (a) begin
        m_eject = 1;
        m_ships++;
      end
    end else if (arr) begin
      box_q.push_back(p);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_led"},   int'(state_led),    exp_led());
    chk({tag, "_ready"}, int'(box_ready),    int'(exp_led() == 2));
    chk({tag, "_pkg"},   int'(pkg_cnt),      box_q.size());
    chk({tag, "_pairs"}, int'(pairs_in_box), box_sum());
    chk({tag, "_boxes"}, int'(box_cnt),      m_ships % 256);
    chk({tag, "_hold"},  int'(hold_full),    held_q.size());
    chk({tag, "_ovf"},   int'(overflow),     int'(m_ovf));
  endtask

  task automatic step(input string tag, input bit c, input int p, input bit a);
    co      = c;
    pac     = 3'(p);
    box_ack = a;
    @(posedge clk);
    model_step(c, p, a);
    #1;
    check_all(tag);
    co      = 1'b0;
    pac     = '0;
    box_ack = 1'b0;
  endtask

  // Asserts reset between edges and checks the outputs clear with no clock.
  task automatic async_reset(input string tag);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    chk({tag, "_led"},   int'(state_led),    0);
    chk({tag, "_ready"}, int'(box_ready),    0);
    chk({tag, "_pkg"},   int'(pkg_cnt),      0);
    chk({tag, "_pairs"}, int'(pairs_in_box), 0);
    chk({tag, "_boxes"}, int'(box_cnt),      0);
    chk({tag, "_hold"},  int'(hold_full),    0);
    chk({tag, "_ovf"},   int'(overflow),     0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; co = 1'b0; pac = '0; box_ack = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_all("rst");

    // Fill one box with pac=3.
    for (int i = 0; i < CAP; i++) begin
      step("fill", 1'b1, 3, 1'b0);
      chk("fill_cnt", int'(pkg_cnt), i + 1);
    end
    chk("fill_pairs", int'(pairs_in_box), 12);
    chk("fill_led", int'(state_led), 2);
    chk("fill_ready", int'(box_ready), 1);

    // Ship it.
    step("ack", 1'b0, 0, 1'b1);
    chk("eject_led", int'(state_led), 3);
    chk("eject_boxes", int'(box_cnt), 1);
    step("post_ej", 1'b0, 0, 1'b0);
    chk("post_ej_led", int'(state_led), 0);
    chk("post_ej_pkg", int'(pkg_cnt), 0);

    // Hold then drop while FULL.
    for (int i = 0; i < CAP; i++) step("fill2", 1'b1, int'($urandom_range(1, 7)), 1'b0);
    step("hold", 1'b1, 2, 1'b0);
    chk("hold_full", int'(hold_full), 1);
    step("drop", 1'b1, 5, 1'b0);
    chk("drop_ovf", int'(overflow), 1);
    step("ack2", 1'b0, 0, 1'b1);
    step("reload", 1'b0, 0, 1'b0);
    chk("reload_led", int'(state_led), 1);
    chk("reload_pkg", int'(pkg_cnt), 1);
    chk("reload_pairs", int'(pairs_in_box), 2);
    chk("reload_hold", int'(hold_full), 0);
    chk("reload_ovf", int'(overflow), 1);

    // Arrival and ack together with hold empty.
    for (int i = 1; i < CAP; i++) step("fill3", 1'b1, 1, 1'b0);
    step("sim", 1'b1, 4, 1'b1);
    chk("sim_led", int'(state_led), 3);
    step("sim_post", 1'b0, 0, 1'b0);
    chk("sim_pkg", int'(pkg_cnt), 1);
    chk("sim_pairs", int'(pairs_in_box), 4);
    step("pac0", 1'b1, 0, 1'b0);
    step("ack_fill", 1'b0, 0, 1'b1);
    chk("ignored_pkg", int'(pkg_cnt), 1);

    // Counter wrap over 256 boxes.
    async_reset("rst2");
    for (int b = 0; b < 256; b++) begin
      for (int i = 0; i < CAP; i++) step("wrap_f", 1'b1, int'($urandom_range(1, 7)), 1'b0);
      step("wrap_a", 1'b0, 0, 1'b1);
      step("wrap_e", 1'b0, 0, 1'b0);
    end
    chk("wrap_boxes", int'(box_cnt), 0);
    chk("wrap_ovf", int'(overflow), 0);
    chk("wrap_hold", int'(hold_full), 0);

    // Random traffic.
    for (int i = 0; i < 600; i++)
      step("rnd", 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
           ($urandom_range(0, 9) < 3));

    // Reset mid-handshake with hold occupied.
    async_reset("rst3");
    for (int i = 0; i < CAP; i++) step("fill4", 1'b1, 6, 1'b0);
    step("hold4", 1'b1, 7, 1'b0);
    chk("pre_rst_hold", int'(hold_full), 1);
    chk("pre_rst_led", int'(state_led), 2);
    async_reset("rst_full");
    step("after_rst", 1'b1, 5, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
